// File: rtl/randomizer_ctrl.sv
// randomizer_ctrl
// Sequences an external PRBS15 LFSR to scramble a byte stream serially.
// A burst request loads the LFSR with a 15-bit seed, MSB first. Payload bytes
// are then fetched one at a time and sent out MSB first as out_bit. Each
// out_bit is lfsr_bit XOR the payload bit.
//
// Ports
//   clk, async_reset_n         clock, asynchronous active-low reset
//   start, seed, len_bytes     burst request; seed and length captured in IDLE
//                              (len_bytes == 0 means 2^LEN_W bytes)
//   in_data, in_valid/in_ready payload byte handshake
//   lfsr_enable/load/din       drive the external LFSR
//   lfsr_bit                   registered LFSR serial output
//   out_bit, out_valid         scrambled serial stream
//   busy, done                 activity flag, end-of-burst pulse
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// SEED  | 15 cycles shifting the seed into the LFSR (load=1)
// FETCH | in_ready=1, LFSR holds, waiting for a payload byte
// BITS  | 8 cycles stepping the LFSR, one payload bit per cycle
// FLUSH | last out_valid of the burst, done=1

module randomizer_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             async_reset_n,
    input  logic             start,
    input  logic [15:1]      seed,
    input  logic [LEN_W-1:0] len_bytes,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             lfsr_enable,
    output logic             lfsr_load,
    output logic             lfsr_din,
    input  logic             lfsr_bit,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED  = 3'd1,
        FETCH = 3'd2,
        BITS  = 3'd3,
        FLUSH = 3'd4
    } state_t;

    localparam logic [3:0] SEED_LAST = 4'd14;

    state_t           state_q;
    state_t           state_d;
    logic [15:1]      seed_q;
    logic [3:0]       seed_cnt_q;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] rem_dec;
    logic [7:0]       pay_q;
    logic [2:0]       bit_cnt_q;
    logic             dly_q;
    logic             ov_q;

    // Wraps, so a captured length of 0 runs for the full 2^LEN_W bytes.
    assign rem_dec = rem_q - {{(LEN_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SEED;
            SEED:    if (seed_cnt_q == 4'd0) state_d = FETCH;
            FETCH:   if (in_valid) state_d = BITS;
            BITS: begin
                if (bit_cnt_q == 3'd0) begin
                    state_d = (rem_dec == '0) ? FLUSH : FETCH;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        lfsr_enable = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_din    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state_q)
            IDLE:  busy = 1'b0;
            SEED: begin
                lfsr_enable = 1'b1;
                lfsr_load   = 1'b1;
                lfsr_din    = seed_q[15];
            end
            FETCH: in_ready = 1'b1;
            BITS:  lfsr_enable = 1'b1;
            FLUSH: done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // The LFSR bit and the delayed payload bit are both registered on the
    // same BITS edge, so they line up one cycle later.
    assign out_valid = ov_q;
    assign out_bit   = ov_q & (lfsr_bit ^ dly_q);

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q    <= IDLE;
            seed_q     <= '0;
            seed_cnt_q <= '0;
            rem_q      <= '0;
            pay_q      <= '0;
            bit_cnt_q  <= '0;
            dly_q      <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            ov_q    <= (state_q == BITS);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        seed_q     <= seed;
                        rem_q      <= len_bytes;
                        seed_cnt_q <= SEED_LAST;
                    end
                end
                SEED: begin
                    seed_q <= {seed_q[14:1], 1'b0};
                    if (seed_cnt_q != 4'd0) seed_cnt_q <= seed_cnt_q - 4'd1;
                end
                FETCH: begin
                    if (in_valid) begin
                        pay_q     <= in_data;
                        bit_cnt_q <= 3'd7;
                    end
                end
                BITS: begin
                    // Payload register stays intact; bits are picked by index.
                    dly_q     <= pay_q[bit_cnt_q];
                    bit_cnt_q <= bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) rem_q <= rem_dec;
                end
                default: ;
            endcase
        end
    end

endmodule
